// File: rtl/sp_ram_pkg.sv
// Shared types and derived constants for the parametrised single-port RAM.
package sp_ram_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Number of byte lanes in a data word.
   function automatic int unsigned be_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

   // Read latency in cycles from accept edge to response.
   function automatic int unsigned rd_lat(input int unsigned out_reg);
      return 1 + out_reg;
   endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Storage array: byte-masked write, registered read, no reset on contents.
module sp_ram_array
   import sp_ram_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned IDX_W  = 5
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [be_w(DATA_W)-1:0]   be,
   input  logic [IDX_W-1:0]          addr,
   input  logic [DATA_W-1:0]         wdata,
   output logic [DATA_W-1:0]         rdata
);

   localparam int unsigned BE_W = be_w(DATA_W);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
               mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/sp_ram_param.sv
// Single-port RAM with valid/ready requests, byte enables, post-reset clear
// sequence and configurable read latency (1 or 2 cycles).
module sp_ram_param
   import sp_ram_pkg::*;
#(
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       ADDR_W   = 5,
   parameter int unsigned       DEPTH    = 32,
   parameter int unsigned       OUT_REG  = 0,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [be_w(DATA_W)-1:0] req_be,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [DATA_W-1:0]       req_wdata,
   output logic                    rsp_valid,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    rsp_err,
   output logic                    init_done
);

   localparam int unsigned BE_W   = be_w(DATA_W);
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned RD_LAT = rd_lat(OUT_REG);
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               req_ready_q, req_ready_d;
   logic               init_done_q, init_done_d;
   logic               rd_vld1_q, rd_vld1_d;
   logic               rd_err1_q, rd_err1_d;

   logic               accept;
   logic               in_range;
   logic               arr_we;
   logic [BE_W-1:0]    arr_be;
   logic [IDX_W-1:0]   arr_addr;
   logic [DATA_W-1:0]  arr_wdata;
   logic [DATA_W-1:0]  arr_rdata;
   logic [DATA_W-1:0]  rd_data_c;

   // FSM, clear counter, range check and first response stage.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept    = req_valid & req_ready_q & reset;
      in_range  = {1'b0, req_addr} < DEPTH_C;
      arr_we    = 1'b0;
      arr_be    = req_be;
      arr_addr  = in_range ? IDX_W'(req_addr) : '0;
      arr_wdata = req_wdata;
      rd_vld1_d = 1'b0;
      rd_err1_d = 1'b0;

      case (state_q)
         ST_INIT: begin
            arr_we    = 1'b1;
            arr_be    = '1;
            arr_addr  = IDX_W'(cnt_q);
            arr_wdata = INIT_VAL;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            arr_we    = accept & req_we & in_range;
            rd_vld1_d = accept & ~req_we;
            rd_err1_d = accept & ~req_we & ~in_range;
         end
         default: state_d = ST_INIT;
      endcase

      if (!reset) begin
         state_d   = ST_INIT;
         cnt_d     = '0;
         arr_we    = 1'b0;
         rd_vld1_d = 1'b0;
         rd_err1_d = 1'b0;
      end

      req_ready_d = reset & (state_d == ST_READY);
      init_done_d = reset & (state_d == ST_READY);
   end

   always_ff @(posedge clk) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      init_done_q <= init_done_d;
      rd_vld1_q   <= rd_vld1_d;
      rd_err1_q   <= rd_err1_d;
   end

   sp_ram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .be    (arr_be),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   // Out-of-range reads return zero regardless of array contents.
   assign rd_data_c = rd_err1_q ? '0 : arr_rdata;

   assign req_ready = req_ready_q;
   assign init_done = init_done_q;

   if (RD_LAT == 1) begin : g_lat1
      logic [DATA_W-1:0] hold_q, hold_d;

      // Array output is shown while valid, otherwise the last delivered word.
      always_comb begin
         hold_d = hold_q;
         if (rd_vld1_q) begin
            hold_d = rd_data_c;
         end
         if (!reset) begin
            hold_d = '0;
         end
      end

      always_ff @(posedge clk) begin
         hold_q <= hold_d;
      end

      assign rsp_valid = rd_vld1_q;
      assign rsp_err   = rd_err1_q;
      assign rsp_rdata = rd_vld1_q ? rd_data_c : hold_q;
   end else begin : g_lat2
      logic              rsp_valid_q, rsp_valid_d;
      logic              rsp_err_q, rsp_err_d;
      logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

      always_comb begin
         rsp_valid_d = rd_vld1_q;
         rsp_err_d   = rd_err1_q;
         rsp_rdata_d = rsp_rdata_q;
         if (rd_vld1_q) begin
            rsp_rdata_d = rd_data_c;
         end
         if (!reset) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
         end
      end

      always_ff @(posedge clk) begin
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end

      assign rsp_valid = rsp_valid_q;
      assign rsp_err   = rsp_err_q;
      assign rsp_rdata = rsp_rdata_q;
   end

endmodule

// File: doc/sp_ram_param.md
Name: sp_ram_param

Overview:
- Parametrised single-port synchronous RAM with a valid/ready request channel, per-byte write enables, configurable read latency and an automatic memory-clear sequence after reset.
- Successor to the team's fixed 32x8 single-port RAM.
- Drives a defined value on rsp_rdata at all times, never Z.
- Sits behind bus adapters as the general-purpose scratch store.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width.
- DEPTH, 32, number of words; DEPTH <= 2**ADDR_W, need not be a power of two.
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register for read latency 2.
- INIT_VAL, 0, DATA_W-bit value written to every word during the clear sequence.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid (single-cycle pulse per read).
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  qualifies rsp_valid; set when the read address was out of range.
- init_done  out  1  clear sequence finished.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-low.
- Reset (reset=0 sampled at a clk edge):
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - State goes to ST_INIT with clear counter 0. All in-flight read responses, including the OUT_REG pipeline stage, are discarded.
- ST_INIT (clear sequence):
  - Each cycle, write INIT_VAL to memory[cnt], then cnt++.
  - After writing word DEPTH-1, go to ST_READY. The clear takes exactly DEPTH cycles after reset deassertion.
  - req_ready=0 throughout. Requests are ignored.
  - Reset asserted mid-clear restarts the sequence from address 0.
- ST_READY:
  - init_done=1 and req_ready=1 every cycle.
  - Accept = req_valid & req_ready. At most one operation per cycle (single port). Full throughput: back-to-back accepts allowed.
- Write accept:
  - For each byte i with req_be[i]=1, memory[addr] byte i <= req_wdata byte i. Other bytes are unchanged.
  - req_be=0 is a legal no-op.
  - Writes produce no response.
- Read accept:
  - OUT_REG=0: rsp_valid=1 on the cycle after the accept edge, with rsp_rdata = memory[addr].
  - OUT_REG=1: same, one cycle later.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. There is no bypass; this follows from the one-op-per-cycle port.
- rsp_rdata holds its last value when rsp_valid=0. It is never Z or X after reset.
- Out-of-range address (req_addr >= DEPTH):
  - Write: dropped, memory unchanged.
  - Read: rsp_valid pulses at normal latency with rsp_rdata=0 and rsp_err=1.
  - rsp_err=0 on all other responses.
- No internal backpressure and no response-side ready; the consumer must sink every response.
- Counters and addresses are ADDR_W+1 bits wide internally, so DEPTH = 2**ADDR_W does not wrap early.

Decomposition:
- Package sp_ram_pkg holds:
  - state enum {ST_INIT, ST_READY};
  - localparam function for BE_W = DATA_W/8;
  - latency constant RD_LAT = 1 + OUT_REG.
- Sub-module sp_ram_array: storage only.
  - Ports: clk, we, be, addr, wdata, rdata.
  - Registered read, byte-masked write, no reset on the array.
- Top level holds the FSM, clear counter, range check, valid/err pipeline and output register.

Test Plan:
- Reset then release, DEPTH=32, INIT_VAL=8'hA5:
  - init_done rises exactly 32 cycles after release;
  - req_ready stays 0 until then;
  - reads of addresses 0, 17 and 31 return 8'hA5 with rsp_err=0.
- DATA_W=32, write 32'h11223344 to addr 3 with be=4'b1111, then write 32'hFFFFFFFF with be=4'b0101, then read addr 3 -> 32'h11FF33FF. Run with OUT_REG=0 (latency 1) and OUT_REG=1 (latency 2).
- Back-to-back stream, one request every cycle:
  - writes to addrs 0..7 with data = addr+1;
  - then reads of 0..7 -> eight consecutive rsp_valid pulses returning 1..8, in order, at fixed latency.
- DEPTH=20, ADDR_W=5:
  - write 8'h5A to addr 25 -> no memory change;
  - read addr 25 -> rsp_valid with rsp_rdata=0, rsp_err=1;
  - read addr 19 -> INIT_VAL with rsp_err=0.
- Reset mid-clear: assert reset at clear cycle 10, then release -> init_done rises DEPTH cycles after the second release.
- Reset with a read in flight (OUT_REG=1): reset asserted the cycle after the accept -> no rsp_valid is ever produced for that read; outputs return to reset values.
